// File: rtl/core_xreg_warb.sv
// core_xreg_warb: arbitrates the EX and LSU writeback sources onto the single
// integer register-file write port. The winner is registered and issued one
// cycle after its handshake. Writes to x0 are acknowledged and dropped.
module core_xreg_warb #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned PRIO_MODE = 0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              src0_vld_i,
   input  logic [ADDR_W-1:0] src0_addr_i,
   input  logic [DATA_W-1:0] src0_data_i,
   output logic              src0_rdy_o,
   input  logic              src1_vld_i,
   input  logic [ADDR_W-1:0] src1_addr_i,
   input  logic [DATA_W-1:0] src1_data_i,
   output logic              src1_rdy_o,
   output logic [ADDR_W-1:0] reg_waddr_o,
   output logic              reg_waddr_vld_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic [CNT_W-1:0]  conflict_cnt_o
);

   localparam bit FIXED_PRIO = (PRIO_MODE != 0);

   logic live0_c;
   logic live1_c;
   logic null0_c;
   logic null1_c;
   logic both_c;
   logic gnt0_c;
   logic gnt1_c;
   logic rr_ptr;

   // Classify requests and pick the winner among live (non-x0) requests
   always_comb begin
      live0_c = src0_vld_i && (src0_addr_i != '0);
      live1_c = src1_vld_i && (src1_addr_i != '0);
      null0_c = src0_vld_i && (src0_addr_i == '0);
      null1_c = src1_vld_i && (src1_addr_i == '0);
      both_c  = live0_c && live1_c;
      gnt0_c  = 1'b0;
      gnt1_c  = 1'b0;
      if (both_c) begin
         if (FIXED_PRIO) begin
            gnt1_c = 1'b1;
         end else begin
            gnt0_c = !rr_ptr;
            gnt1_c = rr_ptr;
         end
      end else begin
         gnt0_c = live0_c;
         gnt1_c = live1_c;
      end
   end

   // Handshake acknowledges; suppressed while reset is asserted
   always_comb begin
      src0_rdy_o = rst_n_i && (gnt0_c || null0_c);
      src1_rdy_o = rst_n_i && (gnt1_c || null1_c);
   end

   // Round-robin pointer: after a live grant, prefer the other source
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rr_ptr <= 1'b0;
      end else if (gnt0_c) begin
         rr_ptr <= 1'b1;
      end else if (gnt1_c) begin
         rr_ptr <= 1'b0;
      end
   end

   // Register-file write stage; addr/data hold when no write issues
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         reg_waddr_vld_o <= 1'b0;
         reg_waddr_o     <= '0;
         reg_wdata_o     <= '0;
      end else begin
         reg_waddr_vld_o <= gnt0_c || gnt1_c;
         if (gnt0_c) begin
            reg_waddr_o <= src0_addr_i;
            reg_wdata_o <= src0_data_i;
         end else if (gnt1_c) begin
            reg_waddr_o <= src1_addr_i;
            reg_wdata_o <= src1_data_i;
         end
      end
   end

   // Saturating count of cycles where both sources were live
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         conflict_cnt_o <= '0;
      end else if (both_c && (conflict_cnt_o != '1)) begin
         conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_core_xreg_warb.sv
// Bench for core_xreg_warb: round-robin (16-bit counter) and fixed-priority
// (4-bit counter) instances share stimulus; a reference model pushes expected
// writes into per-instance queues that are popped when the write stage updates.
module tb_core_xreg_warb;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef struct {
      logic              vld;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s0_vld = 1'b0;
   logic [ADDR_W-1:0] s0_addr = '0;
   logic [DATA_W-1:0] s0_data = '0;
   logic              s1_vld = 1'b0;
   logic [ADDR_W-1:0] s1_addr = '0;
   logic [DATA_W-1:0] s1_data = '0;

   logic [1:0]        o_rdy0;
   logic [1:0]        o_rdy1;
   logic [1:0]        o_vld;
   logic [ADDR_W-1:0] o_addr [2];
   logic [DATA_W-1:0] o_data [2];
   logic [15:0]       o_cnt0;
   logic [3:0]        o_cnt1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   exp_t        q [2][$];
   logic        m_ptr [2];
   int unsigned m_cnt [2];
   int unsigned m_max [2];
   logic [ADDR_W-1:0] m_laddr [2];
   logic [DATA_W-1:0] m_ldata [2];

   always #5 clk = !clk;

   core_xreg_warb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRIO_MODE(0), .CNT_W(16)) u_rr (
      .clk_i(clk), .rst_n_i(rst_n),
      .src0_vld_i(s0_vld), .src0_addr_i(s0_addr), .src0_data_i(s0_data), .src0_rdy_o(o_rdy0[0]),
      .src1_vld_i(s1_vld), .src1_addr_i(s1_addr), .src1_data_i(s1_data), .src1_rdy_o(o_rdy1[0]),
      .reg_waddr_o(o_addr[0]), .reg_waddr_vld_o(o_vld[0]), .reg_wdata_o(o_data[0]),
      .conflict_cnt_o(o_cnt0)
   );

   core_xreg_warb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRIO_MODE(1), .CNT_W(4)) u_fp (
      .clk_i(clk), .rst_n_i(rst_n),
      .src0_vld_i(s0_vld), .src0_addr_i(s0_addr), .src0_data_i(s0_data), .src0_rdy_o(o_rdy0[1]),
      .src1_vld_i(s1_vld), .src1_addr_i(s1_addr), .src1_data_i(s1_data), .src1_rdy_o(o_rdy1[1]),
      .reg_waddr_o(o_addr[1]), .reg_waddr_vld_o(o_vld[1]), .reg_wdata_o(o_data[1]),
      .conflict_cnt_o(o_cnt1)
   );

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         q[k].delete();
         m_ptr[k]   = 1'b0;
         m_cnt[k]   = 0;
         m_laddr[k] = '0;
         m_ldata[k] = '0;
      end
   endtask

   function automatic logic [63:0] dut_cnt(input int k);
      return (k == 0) ? 64'(o_cnt0) : 64'(o_cnt1);
   endfunction

   // Compare the write stage and counter against the oldest expectation
   task automatic check_outputs();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (q[k].size() > 0) e = q[k].pop_front();
         else e = '{vld: 1'b0, addr: m_laddr[k], data: m_ldata[k]};
         chk($sformatf("d%0d_vld", k),  64'(o_vld[k]),  64'(e.vld));
         chk($sformatf("d%0d_addr", k), 64'(o_addr[k]), 64'(e.addr));
         chk($sformatf("d%0d_data", k), 64'(o_data[k]), 64'(e.data));
         chk($sformatf("d%0d_cnt", k),  dut_cnt(k),     64'(m_cnt[k]));
      end
   endtask

   // One cycle: check registered outputs, drive inputs, check rdy, predict
   task automatic step(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      logic l0, l1, g0, g1;
      exp_t e;
      @(negedge clk);
      check_outputs();
      s0_vld = v0; s0_addr = a0; s0_data = d0;
      s1_vld = v1; s1_addr = a1; s1_data = d1;
      #1;
      l0 = v0 && (a0 != 0);
      l1 = v1 && (a1 != 0);
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin
            g1 = l1;
            g0 = l0 && !l1;
         end else begin
            g0 = l0 && (!l1 || !m_ptr[k]);
            g1 = l1 && (!l0 ||  m_ptr[k]);
         end
         chk($sformatf("d%0d_rdy0", k), 64'(o_rdy0[k]), 64'(g0 || (v0 && a0 == 0)));
         chk($sformatf("d%0d_rdy1", k), 64'(o_rdy1[k]), 64'(g1 || (v1 && a1 == 0)));
         if (g0) begin m_laddr[k] = a0; m_ldata[k] = d0; m_ptr[k] = 1'b1; end
         if (g1) begin m_laddr[k] = a1; m_ldata[k] = d1; m_ptr[k] = 1'b0; end
         e = '{vld: g0 || g1, addr: m_laddr[k], data: m_ldata[k]};
         q[k].push_back(e);
         if (l0 && l1 && m_cnt[k] < m_max[k]) m_cnt[k]++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s0_vld = 1'b0; s1_vld = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [ADDR_W-1:0] amap [5];
      logic [ADDR_W-1:0] ra0, ra1;
      amap[0] = 5'd0; amap[1] = 5'd1; amap[2] = 5'd2; amap[3] = 5'd3; amap[4] = 5'd31;
      m_max[0] = 32'hFFFF;
      m_max[1] = 32'hF;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Quiet after reset release
      idle(10);

      // Single src0 write
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
      idle(2);

      // Continuous contention from reset pointer
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i);
      idle(2);

      // Null request alongside a live one
      step(1'b1, 5'd3, 32'h333, 1'b1, 5'd0, 32'h999);
      idle(1);
      step(1'b1, 5'd4, 32'h444, 1'b1, 5'd6, 32'h666);
      idle(2);

      // Same-destination contention, loser retries
      step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
      step(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0);
      idle(2);

      // Random mix including x0 requests
      for (int i = 0; i < 150; i++) begin
         ra0 = amap[$urandom_range(0, 4)];
         ra1 = amap[$urandom_range(0, 4)];
         step(1'($urandom_range(0, 1)), ra0, $urandom, 1'($urandom_range(0, 1)), ra1, $urandom);
      end
      idle(2);

      // Reset during the cycle after a grant drops the pending write
      step(1'b1, 5'd9, 32'hAA, 1'b0, '0, '0);
      @(posedge clk);
      #2;
      check_outputs();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_rst_vld", k),  64'(o_vld[k]),  64'(0));
         chk($sformatf("d%0d_rst_rdy0", k), 64'(o_rdy0[k]), 64'(0));
         chk($sformatf("d%0d_rst_addr", k), 64'(o_addr[k]), 64'(0));
         chk($sformatf("d%0d_rst_cnt", k),  dut_cnt(k),     64'(0));
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      s0_vld = 1'b0;
      idle(3);

      // Counter saturation (narrow counter wraps quickly if unsaturated)
      for (int i = 0; i < 20; i++) step(1'b1, 5'd4, 32'h40 + i, 1'b1, 5'd6, 32'h60 + i);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
